wb_uart_tx_master: RTL and testbench
====================================

WB_UART_TX_MASTER -- requirements
Module: wb_uart_tx_master

Interface
REQ-001 The block SHALL have parameter UART_BASE, default 32'h90000000, meaning the byte address of the 16550 register file.
REQ-002 The block SHALL have parameter DIVISOR, default 16'd27, meaning the baud divisor written to DLL/DLM.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles a bus access waits for ack/err.
REQ-004 wb_clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-005 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-006 wb_adr_o  out  32  Wishbone address, UART_BASE + register offset (0..7).
REQ-007 wb_dat_o  out  8  write data; wb_we_o out 1 write enable; wb_cyc_o, wb_stb_o out 1 each.
REQ-008 wb_cti_o  out  3  constant 3'b000 (classic); wb_bte_o out 2, constant 2'b00.
REQ-009 wb_dat_i  in  8  read data; wb_ack_i, wb_err_i, wb_rty_i in 1 each.
REQ-010 s_data  in  8  byte to transmit; s_valid in 1; s_ready out 1 (byte accepted when s_valid && s_ready).
REQ-011 init_done  out  1  UART configured; err_o out 1 sticky bus error/timeout flag.

Function
REQ-012 The FSM SHALL have states INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, IDLE, POLL_LSR, WRITE_THR, ERROR.
REQ-013 After reset, the block SHALL perform writes in order: offset 3 <- 8'h80, offset 0 <- DIVISOR[7:0], offset 1 <- DIVISOR[15:8], offset 3 <- 8'h03 (8N1, DLAB=0), then enter IDLE and set init_done.
REQ-014 Each access SHALL assert cyc and stb together with stable adr/dat/we, and hold them until the cycle in which ack, err or timeout occurs; cyc/stb SHALL deassert the following cycle (minimum one idle cycle between accesses).
REQ-015 ack SHALL complete the access; rty SHALL end the access and reissue the same access after one idle cycle; err or TIMEOUT cycles without ack/err SHALL end the access, set err_o and enter ERROR.
REQ-016 ack, err, rty sampled while cyc/stb are low SHALL be ignored.
REQ-017 s_ready SHALL be high only in IDLE with init_done set; a handshake SHALL latch s_data into a holding register and move to POLL_LSR the next cycle.
REQ-018 POLL_LSR SHALL read offset 5 (we=0); on ack with wb_dat_i[5]=1 (THRE) go to WRITE_THR, else reissue the read after one idle cycle.
REQ-019 WRITE_THR SHALL write the held byte to offset 0; on ack return to IDLE, so one byte is in flight at most.
REQ-020 ERROR SHALL be terminal: cyc/stb low, s_ready low, err_o high until reset.
REQ-021 Timeout counter SHALL be 8 bits minimum, clear at each access start, and trigger when count reaches TIMEOUT.
REQ-022 If ack and err are both high in one cycle, err SHALL take priority.

Reset
REQ-023 While wb_rst_i is high: wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, s_ready=0, init_done=0, err_o=0, state=INIT_LCR_DLAB, counters 0.
REQ-024 Reset asserted mid-access SHALL drop cyc/stb immediately (asynchronously) and restart the full init sequence on release.

Structure
REQ-025 Register offsets (THR/DLL=0, DLM=1, LCR=3, LSR=5), LCR values, the LSR THRE bit index and the state enumeration SHALL live in a shared package uart16550_pkg.
REQ-026 The Wishbone single-access engine (request, ack/err/rty/timeout handling) SHALL be a sub-module wb_single_access; the sequencing FSM lives in the top.

Verification
REQ-027 Reset release with responder acking in 1 cycle -> exactly four writes (3:80, 0:1B, 1:00, 3:03), then init_done=1, s_ready=1.
REQ-028 Send 8'h41 with LSR returning 8'h00 twice then 8'h60 -> three reads of offset 5, then one write 0:41, s_ready low throughout, high after ack.
REQ-029 Responder asserts rty once on the DLL write -> DLL write reissued after one idle cycle, sequence otherwise unchanged.
REQ-030 Responder never acks the LSR read -> after 255 cycles cyc/stb drop, err_o=1, s_ready stays 0.
REQ-031 Assert wb_rst_i during the THR write -> cyc/stb low same cycle; after release init sequence repeats from LCR 8'h80.
REQ-032 Back-to-back bytes 8'h48, 8'h69 with s_valid held -> two THR writes in order, each preceded by at least one LSR read.

Source files
------------

// File: rtl/uart16550_pkg.sv
// Shared 16550 register map, LCR/LSR constants, sequencer states and the
// request/response types exchanged between the sequencer and the bus engine.
package uart16550_pkg;

  localparam logic [2:0] OFF_THR = 3'd0;
  localparam logic [2:0] OFF_DLL = 3'd0;
  localparam logic [2:0] OFF_DLM = 3'd1;
  localparam logic [2:0] OFF_LCR = 3'd3;
  localparam logic [2:0] OFF_LSR = 3'd5;

  localparam logic [7:0] LCR_DLAB = 8'h80;
  localparam logic [7:0] LCR_8N1  = 8'h03;
  localparam int         LSR_THRE = 5;

  typedef enum logic [2:0] {
    INIT_LCR_DLAB,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    IDLE,
    POLL_LSR,
    WRITE_THR,
    ERROR
  } state_t;

  typedef struct packed {
    logic [2:0] off;
    logic       we;
    logic [7:0] dat;
  } acc_req_t;

  typedef struct packed {
    logic       ack;
    logic       rty;
    logic       err;
    logic [7:0] rdata;
  } acc_rsp_t;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [2:0] off);
    return base + {29'd0, off};
  endfunction

endpackage

// File: rtl/wb_single_access.sv
// Classic Wishbone single-access engine: latches one request, holds cyc/stb
// until ack/err/rty or timeout, then idles at least one cycle.
module wb_single_access
  import uart16550_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h9000_0000,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_vld_i,
  input  acc_req_t    req_i,
  output acc_rsp_t    rsp_o,
  output logic [31:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic          cyc_q, cyc_d, we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo, done;

  // Timeout fires on the TIMEOUT-th cycle of an unanswered access.
  assign tmo         = cyc_q && (cnt_q == CW'(TIMEOUT - 1));
  assign rsp_o.err   = cyc_q && (wb_err_i || (tmo && !wb_ack_i && !wb_rty_i));
  assign rsp_o.ack   = cyc_q && wb_ack_i && !wb_err_i;
  assign rsp_o.rty   = cyc_q && wb_rty_i && !wb_ack_i && !wb_err_i;
  assign rsp_o.rdata = wb_dat_i;
  assign done        = rsp_o.err || rsp_o.ack || rsp_o.rty;

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

  always_comb begin
    cyc_d = cyc_q;
    adr_d = adr_q;
    dat_d = dat_q;
    we_d  = we_q;
    cnt_d = cnt_q;
    if (!cyc_q) begin
      if (req_vld_i) begin
        cyc_d = 1'b1;
        adr_d = reg_addr(BASE, req_i.off);
        dat_d = req_i.dat;
        we_d  = req_i.we;
        cnt_d = '0;
      end
    end else if (done) begin
      cyc_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      we_q  <= we_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_uart_tx_master.sv
// Configures a 16550 UART over Wishbone, then streams bytes to THR, polling
// LSR.THRE before each write; any bus error or timeout parks it in ERROR.
module wb_uart_tx_master
  import uart16550_pkg::*;
#(
  parameter logic [31:0] UART_BASE = 32'h9000_0000,
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter int          TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [31:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        init_done,
  output logic        err_o
);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       init_q, init_d, err_q, err_d;
  logic       req_vld;
  acc_req_t   req;
  acc_rsp_t   rsp;
  logic       unused_rsp;

  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;
  assign s_ready    = (state_q == IDLE) && init_q;
  assign init_done  = init_q;
  assign err_o      = err_q;
  // rty needs no sequencer action: holding the request reissues it.
  assign unused_rsp = ^{rsp.rty, rsp.rdata};

  wb_single_access #(.BASE(UART_BASE), .TIMEOUT(TIMEOUT)) u_acc (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .req_vld_i (req_vld),
    .req_i     (req),
    .rsp_o     (rsp),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_we_o   (wb_we_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .wb_rty_i  (wb_rty_i)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    init_d  = init_q;
    err_d   = err_q;
    req_vld = 1'b0;
    req.off = OFF_LCR;
    req.we  = 1'b1;
    req.dat = 8'h00;
    unique case (state_q)
      INIT_LCR_DLAB: begin
        req_vld = 1'b1;
        req.dat = LCR_DLAB;
        if (rsp.ack) state_d = INIT_DLL;
      end
      INIT_DLL: begin
        req_vld = 1'b1;
        req.off = OFF_DLL;
        req.dat = DIVISOR[7:0];
        if (rsp.ack) state_d = INIT_DLM;
      end
      INIT_DLM: begin
        req_vld = 1'b1;
        req.off = OFF_DLM;
        req.dat = DIVISOR[15:8];
        if (rsp.ack) state_d = INIT_LCR;
      end
      INIT_LCR: begin
        req_vld = 1'b1;
        req.dat = LCR_8N1;
        if (rsp.ack) begin
          state_d = IDLE;
          init_d  = 1'b1;
        end
      end
      IDLE: begin
        if (s_valid && s_ready) begin
          hold_d  = s_data;
          state_d = POLL_LSR;
        end
      end
      POLL_LSR: begin
        req_vld = 1'b1;
        req.off = OFF_LSR;
        req.we  = 1'b0;
        if (rsp.ack && rsp.rdata[LSR_THRE]) state_d = WRITE_THR;
      end
      WRITE_THR: begin
        req_vld = 1'b1;
        req.off = OFF_THR;
        req.dat = hold_q;
        if (rsp.ack) state_d = IDLE;
      end
      ERROR: ;
      default: ;
    endcase
    if (rsp.err) begin
      state_d = ERROR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= INIT_LCR_DLAB;
      hold_q  <= '0;
      init_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      init_q  <= init_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_uart_tx_master.sv
// Scoreboard bench: stimulus plans the expected bus accesses from the UART
// programming rules; a responder serves them and a monitor checks each one.
module tb_wb_uart_tx_master;

  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int          TMO  = 255;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] wb_adr_o;
  logic [7:0]  wb_dat_o, wb_dat_i, s_data;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        s_valid, s_ready, init_done, err_o;

  always #5 clk = ~clk;

  wb_uart_tx_master #(.UART_BASE(BASE), .DIVISOR(16'd27), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .init_done(init_done), .err_o(err_o)
  );

  // kind: 0 ack, 1 rty, 2 never answer, 3 ack+err together
  typedef struct {
    logic [2:0] off;
    logic       we;
    logic [7:0] dat;
    int         kind;
    int         lat;
    logic [7:0] rdata;
  } acc_t;

  acc_t exp_q[$];
  acc_t plan_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic plan(input logic [2:0] off, input logic we, input logic [7:0] dat,
                      input int kind, input logic [7:0] rd);
    acc_t a;
    a.off = off; a.we = we; a.dat = dat; a.kind = kind;
    a.lat = $urandom_range(0, 2); a.rdata = rd;
    exp_q.push_back(a);
    plan_q.push_back(a);
  endtask

  task automatic plan_init(input bit rty_dll);
    plan(3'd3, 1'b1, 8'h80, 0, 8'h00);
    if (rty_dll) plan(3'd0, 1'b1, 8'h1B, 1, 8'h00);
    plan(3'd0, 1'b1, 8'h1B, 0, 8'h00);
    plan(3'd1, 1'b1, 8'h00, 0, 8'h00);
    plan(3'd3, 1'b1, 8'h03, 0, 8'h00);
  endtask

  // A byte costs `busy` LSR reads without THRE, one with THRE, then the THR write.
  task automatic plan_byte(input logic [7:0] b, input int busy, input bit rty);
    for (int i = 0; i < busy; i++) plan(3'd5, 1'b0, 8'h00, 0, 8'($urandom) & 8'hDF);
    plan(3'd5, 1'b0, 8'h00, 0, 8'($urandom) | 8'h20);
    if (rty) plan(3'd0, 1'b1, b, 1, 8'h00);
    plan(3'd0, 1'b1, b, 0, 8'h00);
  endtask

  task automatic finish_acc(input logic [31:0] a, input logic w, input logic [7:0] d,
                            input bit bad, input bit resp, input int held);
    acc_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL unexpected_access: adr=%h we=%0d dat=%h, expected no access", a, w, d);
      return;
    end
    e = exp_q.pop_front();
    chk("access_adr_we_dat", {a, w, (w ? d : 8'h00)},
        {BASE + {29'd0, e.off}, e.we, (e.we ? e.dat : 8'h00)});
    chk("access_stable", bad, 0);
    if (resp) chk("s_ready_during_access", s_ready, 0);
    else begin
      chk("timeout_expected", e.kind, 2);
      chk("timeout_len", held, TMO);
    end
  endtask

  // Responder: drives ack/rty/err just after the clock edge per the plan.
  initial begin : responder
    acc_t cur;
    int   cnt;
    bit   act;
    act = 0; cnt = 0;
    cur.kind = 0; cur.lat = 0; cur.rdata = 0;
    wb_ack_i = 0; wb_rty_i = 0; wb_err_i = 0; wb_dat_i = 0;
    forever begin
      @(posedge clk); #1;
      wb_ack_i = 0; wb_rty_i = 0; wb_err_i = 0; wb_dat_i = 8'($urandom);
      if (rst) begin act = 0; continue; end
      if (wb_cyc_o && wb_stb_o) begin
        if (!act) begin
          act = 1; cnt = 0;
          if (plan_q.size() == 0) begin cur.kind = 0; cur.lat = 0; cur.rdata = 0; end
          else cur = plan_q.pop_front();
        end
        if (cur.kind != 2 && cnt == cur.lat) begin
          case (cur.kind)
            1:       wb_rty_i = 1;
            3:       begin wb_ack_i = 1; wb_err_i = 1; end
            default: begin wb_ack_i = 1; wb_dat_i = cur.rdata; end
          endcase
          act = 0;
        end
        cnt++;
      end else begin
        act = 0;
        // stray responses outside a cycle must be ignored
        wb_ack_i = ($urandom_range(0, 7) == 0);
        wb_rty_i = ($urandom_range(0, 7) == 0);
        wb_err_i = ($urandom_range(0, 7) == 0);
      end
    end
  end

  initial begin : monitor
    logic        pc, we0;
    logic [31:0] a0;
    logic [7:0]  d0;
    int          held;
    bit          rp, bad;
    pc = 0; we0 = 0; a0 = 0; d0 = 0; held = 0; rp = 0; bad = 0;
    forever begin
      @(negedge clk);
      if (rst) begin pc = 0; rp = 0; continue; end
      if (rp) chk("cyc_drop_after_resp", {wb_cyc_o, wb_stb_o}, 0);
      rp = 0;
      if (wb_cyc_o || wb_stb_o) begin
        if (!pc) begin a0 = wb_adr_o; we0 = wb_we_o; d0 = wb_dat_o; held = 0; bad = 0; end
        if (!(wb_cyc_o && wb_stb_o) || wb_adr_o !== a0 || wb_we_o !== we0 || wb_dat_o !== d0)
          bad = 1;
        held++;
        if (wb_ack_i || wb_rty_i || wb_err_i) begin
          finish_acc(a0, we0, d0, bad, 1, held);
          rp = 1; pc = 0;
        end else pc = 1;
      end else if (pc) begin
        finish_acc(a0, we0, d0, bad, 0, held);
        pc = 0;
      end
    end
  end

  task automatic wait_init(input string nm);
    int t = 0;
    while (!init_done && t < 300) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk({nm, "_init_done"}, init_done, 1);
    chk({nm, "_s_ready"}, s_ready, 1);
    chk({nm, "_all_writes"}, exp_q.size(), 0);
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    s_valid = 1; s_data = b;
    while (!s_ready && t < 2000) begin @(negedge clk); t++; end
    chk("handshake_in_time", t < 2000, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || !s_ready) && t < 3000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk({nm, "_drained"}, exp_q.size(), 0);
    chk({nm, "_ready"}, s_ready, 1);
  endtask

  task automatic wait_err(input string nm, input int bound);
    int t = 0;
    while (!err_o && t < bound) begin @(negedge clk); t++; end
    chk({nm, "_err_o"}, err_o, 1);
    s_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk({nm, "_error_quiet"}, {wb_cyc_o, wb_stb_o, s_ready, err_o}, 4'b0001);
    end
    s_valid = 0;
    chk({nm, "_no_more_access"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] b;
    int         t;
    s_valid = 0; s_data = 0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
                            s_ready, init_done, err_o}, 0);
    end
    chk("cti_bte", {wb_cti_o, wb_bte_o}, 0);

    plan_init(0);
    rst = 0;
    wait_init("init1");

    plan(3'd5, 1'b0, 8'h00, 0, 8'h00);
    plan(3'd5, 1'b0, 8'h00, 0, 8'h00);
    plan(3'd5, 1'b0, 8'h00, 0, 8'h60);
    plan(3'd0, 1'b1, 8'h41, 0, 8'h00);
    send(8'h41); s_valid = 0;
    drain("byte41");

    plan_byte(8'h48, $urandom_range(0, 2), 0);
    plan_byte(8'h69, $urandom_range(0, 2), 0);
    send(8'h48); send(8'h69); s_valid = 0;
    drain("back2back");

    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      plan_byte(b, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      send(b);
      if ($urandom_range(0, 1) == 1) begin
        s_valid = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    s_valid = 0;
    drain("random");

    // reset while the THR write is outstanding
    plan(3'd5, 1'b0, 8'h00, 0, 8'h20);
    plan(3'd0, 1'b1, 8'h5A, 2, 8'h00);
    send(8'h5A); s_valid = 0;
    t = 0;
    while (!(wb_cyc_o && wb_we_o && wb_adr_o == BASE) && t < 200) begin @(negedge clk); t++; end
    chk("thr_write_started", t < 200, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1 chk("reset_drops_cyc", {wb_cyc_o, wb_stb_o}, 0);
    repeat (3) @(negedge clk);
    chk("reset_mid_outputs", {wb_cyc_o, wb_stb_o, s_ready, init_done, err_o}, 0);
    exp_q.delete(); plan_q.delete();
    plan_init(1);
    rst = 0;
    wait_init("init2_rty");

    // LSR read never answered
    plan(3'd5, 1'b0, 8'h00, 2, 8'h00);
    send(8'hA5); s_valid = 0;
    wait_err("timeout", 600);

    // ack and err together on the LSR read
    rst = 1;
    repeat (2) @(negedge clk);
    exp_q.delete(); plan_q.delete();
    plan_init(0);
    rst = 0;
    wait_init("init3");
    plan(3'd5, 1'b0, 8'h00, 3, 8'h20);
    send(8'h77); s_valid = 0;
    wait_err("ack_err", 100);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
